// File: rtl/ahb2apb_pkg.sv
// Shared encodings for the AHB-to-APB bridge: htrans codes and FSM states.
// The ERR1/ERR2 states are only reachable when AHB2APB_HRESP_EN is defined.
package ahb2apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  function automatic logic htrans_active(input logic [1:0] trans);
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb2apb_bridge.sv
// AHB-lite slave to APB master bridge, one transfer in flight at a time.
// Define AHB2APB_HRESP_EN to add pslverr/hresp and the two-cycle AHB ERROR response.
module ahb2apb_bridge
  import ahb2apb_pkg::*;
#(
  parameter int AHB_AW = 32,
  parameter int AHB_DW = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hsel,
  input  logic [AHB_AW-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [AHB_DW-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic [AHB_DW-1:0] hrdata,
`ifdef AHB2APB_HRESP_EN
  input  logic              pslverr,
  output logic              hresp,
`endif
  output logic [AHB_AW-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AHB_DW-1:0] pwdata,
  input  logic [AHB_DW-1:0] prdata,
  input  logic              pready
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [AHB_AW-1:0]   r_paddr;
  logic                r_pwrite;
  logic [AHB_DW-1:0]   r_pwdata;
  logic [AHB_DW-1:0]   r_hrdata;
  logic                w_valid;
  logic                w_accept;
  logic                w_done;
  logic                w_err;

  assign w_valid = hsel & hready & htrans_active(htrans);

  // ERR2 already reports hreadyout=1, so it accepts a new transfer just like IDLE.
`ifdef AHB2APB_HRESP_EN
  assign w_accept = w_valid & ((r_state == ST_IDLE) | (r_state == ST_ERR2));
  assign w_err    = pslverr;
`else
  assign w_accept = w_valid & (r_state == ST_IDLE);
  assign w_err    = 1'b0;
`endif

  assign w_done = (r_state == ST_ACCESS) & pready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WLATCH: w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (pready) w_state_nxt = w_err ? ST_ERR1 : ST_IDLE;
`ifdef AHB2APB_HRESP_EN
      ST_ERR1:   w_state_nxt = ST_ERR2;
`endif
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_accept) w_state_nxt = hwrite ? ST_WLATCH : ST_SETUP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Address/direction only move on acceptance, keeping them frozen through SETUP and ACCESS.
      if (w_accept) begin
        r_paddr  <= haddr;
        r_pwrite <= hwrite;
      end
      if (r_state == ST_WLATCH) r_pwdata <= hwdata;
      if (w_done && !r_pwrite && !w_err) r_hrdata <= prdata;
    end
  end

  assign hreadyout = (r_state == ST_IDLE) | (r_state == ST_ERR2);
  assign psel      = (r_state == ST_SETUP) | (r_state == ST_ACCESS);
  assign penable   = (r_state == ST_ACCESS);
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign hrdata    = r_hrdata;
`ifdef AHB2APB_HRESP_EN
  assign hresp     = (r_state == ST_ERR1) | (r_state == ST_ERR2);
`endif

endmodule

// File: doc/ahb2apb_bridge.md
AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

Interface
REQ-001 Parameter AHB_AW, 32, address width on AHB and APB sides.
REQ-002 Parameter AHB_DW, 32, data width on AHB and APB sides.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 hsel  in  1  bridge selected.
REQ-007 haddr  in  AHB_AW  transfer address.
REQ-008 htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 hwrite  in  1  1=write.
REQ-010 hwdata  in  AHB_DW  write data, valid in data phase.
REQ-011 hready  in  1  bus-level ready, previous transfer complete.
REQ-012 hreadyout  out  1  bridge data-phase ready.
REQ-013 hrdata  out  AHB_DW  read data, registered.
REQ-014 paddr  out  AHB_AW; psel  out  1; penable  out  1; pwrite  out  1; pwdata  out  AHB_DW: APB master outputs.
REQ-015 prdata  in  AHB_DW; pready  in  1: APB slave response.

Function
REQ-016 Valid transfer SHALL be sampled when hsel & hready & htrans[1]; IDLE/BUSY, hsel=0 or hready=0 SHALL be ignored.
REQ-017 On a valid transfer, haddr and hwrite SHALL be latched and hreadyout driven 0 in the next cycle.
REQ-018 FSM states: IDLE, WLATCH, SETUP, ACCESS (plus ERR1, ERR2 under REQ-030).
REQ-019 IDLE: valid write -> WLATCH; valid read -> SETUP; else stay. hreadyout=1.
REQ-020 WLATCH: capture hwdata into pwdata, -> SETUP; hreadyout=0, psel=0.
REQ-021 SETUP: psel=1, penable=0, paddr/pwrite/pwdata stable; -> ACCESS unconditionally.
REQ-022 ACCESS: psel=1, penable=1; pready=0 holds ACCESS indefinitely (no timeout); pready=1 -> IDLE, hrdata<=prdata on reads.
REQ-023 Latency (pready=1 first ACCESS cycle): read address phase cycle N, SETUP N+1, ACCESS N+2, hreadyout=1 with hrdata valid N+3; write completes N+4.
REQ-024 Transfer sampled in the completion cycle (IDLE with hreadyout=1) SHALL proceed without idle gap; bursts handled as independent single transfers.
REQ-025 paddr, pwrite, pwdata SHALL not change from SETUP through final ACCESS cycle.
REQ-026 hrdata SHALL hold last read value until the next read completes; writes do not alter it.

Reset
REQ-027 reset_n low SHALL force IDLE at once, including mid-SETUP/ACCESS; transfer abandoned.
REQ-028 Reset values: hreadyout=1, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0 (hresp=0 if present).
REQ-029 After reset release, first valid transfer SHALL be accepted in the first clock with reset_n high.

Configuration
REQ-030 Macro AHB2APB_HRESP_EN: adds ports pslverr (in, 1) and hresp (out, 1); pslverr=1 with pready=1 in ACCESS -> ERR1 (hreadyout=0, hresp=1) -> ERR2 (hreadyout=1, hresp=1) -> IDLE rules; transfers sampled in ERR2 as in IDLE.
REQ-031 Without AHB2APB_HRESP_EN: ports pslverr/hresp absent, ERR states absent, every transfer completes OKAY.

Structure
REQ-032 Package ahb2apb_pkg SHALL hold the FSM state enum and htrans encoding constants.
REQ-033 Single module; no sub-module is warranted.

Verification
REQ-034 Read 0x0000_0010, pready=1, prdata=0xCAFE_0001 -> SETUP N+1, ACCESS N+2, hrdata=0xCAFE_0001 with hreadyout=1 at N+3.
REQ-035 Write 0x0000_0020, hwdata=0x1234_5678 -> psel N+2, penable N+3, pwdata=0x1234_5678 stable, hreadyout=1 N+4.
REQ-036 pready low 5 ACCESS cycles -> psel/penable held, hreadyout=0 throughout, completion one cycle after pready=1.
REQ-037 Back-to-back NONSEQ read then write, htrans=IDLE/BUSY interleaved, hready=0 cycles -> only NONSEQ/SEQ with hready=1 start APB transfers, no gap.
REQ-038 reset_n low during ACCESS -> psel=penable=0, hreadyout=1 immediately; new read after release completes normally.
REQ-039 AHB2APB_HRESP_EN, pslverr=1 -> hresp=1 two cycles, hreadyout 0 then 1; without macro same stimulus completes OKAY.
